// File: rtl/div_req_sequencer.sv
// Request sequencer in front of the signed divider: accepts one divide request,
// launches the divider, waits for its result (or times out) and holds the response.
module div_req_sequencer #(
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        div_start,
    output logic        div_muordi,
    output logic [63:0] div_opera2,
    output logic [31:0] div_opera1,
    input  logic        div_valid,
    input  logic [63:0] div_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [3:0]  START_LAST = 4'(START_CYCLES - 1);
    localparam logic [15:0] RUN_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  start_cnt;
    logic [15:0] run_cnt;
    logic        ready_q;
    logic        start_q;
    logic [63:0] opera2_q;
    logic [31:0] opera1_q;
    logic [63:0] result_q;
    logic [1:0]  err_q;

    logic accept;
    logic divisor_zero;

    assign accept       = req_valid && req_ready;
    assign divisor_zero = (req_divisor == 32'h0);

    // ready_q keeps req_ready low until the first edge after reset release
    assign req_ready  = ready_q && (state == ST_IDLE);
    assign div_start  = start_q;
    assign div_muordi = 1'b1;
    assign div_opera2 = opera2_q;
    assign div_opera1 = opera1_q;
    assign rsp_valid  = (state == ST_DONE);
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = (state != ST_IDLE);

    // start_q resets high so the divider sits in its clear state during reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            start_cnt <= 4'd0;
            run_cnt   <= 16'd0;
            ready_q   <= 1'b0;
            start_q   <= 1'b1;
            opera2_q  <= 64'h0;
            opera1_q  <= 32'h0;
            result_q  <= 64'h0;
            err_q     <= ERR_OK;
        end else begin
            ready_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    start_q <= 1'b0;
                    if (accept) begin
                        opera2_q <= req_dividend;
                        opera1_q <= req_divisor;
                        if (divisor_zero) begin
                            result_q <= {32'h0, req_dividend[31:0]};
                            err_q    <= ERR_DIV0;
                            state    <= ST_DONE;
                        end else begin
                            start_cnt <= 4'd0;
                            start_q   <= 1'b1;
                            state     <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    start_cnt <= start_cnt + 4'd1;
                    if (start_cnt == START_LAST) begin
                        start_q <= 1'b0;
                        run_cnt <= 16'd0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // run_cnt==0 is the arm cycle: a stale valid from the last op is ignored
                    run_cnt <= run_cnt + 16'd1;
                    if ((run_cnt != 16'd0) && div_valid) begin
                        result_q <= div_result;
                        err_q    <= ERR_OK;
                        state    <= ST_DONE;
                    end else if (run_cnt == RUN_LAST) begin
                        result_q <= 64'h0;
                        err_q    <= ERR_TIMEOUT;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed plus randomized bench for div_req_sequencer, with a behavioural divider
// model and an arithmetic reference for the expected responses.
module tb_div_req_sequencer;

    localparam int START_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int DM_NORMAL      = 0;
    localparam int DM_STUCK       = 1;
    localparam int DM_NEVER       = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_dividend;
    logic [31:0] req_divisor;
    logic        div_start;
    logic        div_muordi;
    logic [63:0] div_opera2;
    logic [31:0] div_opera1;
    logic        div_valid;
    logic [63:0] div_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [1:0]  rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int dm_mode = DM_NORMAL;
    int dm_lat  = 3;
    int dm_cnt  = 0;

    div_req_sequencer #(
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_start    (div_start),
        .div_muordi   (div_muordi),
        .div_opera2   (div_opera2),
        .div_opera1   (div_opera1),
        .div_valid    (div_valid),
        .div_result   (div_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] signed_divide(input logic [63:0] a_in, input logic [31:0] b_in);
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] q;
        logic signed [63:0] r;
        a = a_in;
        b = {{32{b_in[31]}}, b_in};
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider model: cleared while start is high, valid is a level held until the next start
    initial begin
        div_valid  = 1'b0;
        div_result = 64'h0;
    end
    always @(posedge clock) begin
        case (dm_mode)
            DM_STUCK: begin
                div_valid  <= 1'b1;
                div_result <= signed_divide(div_opera2, div_opera1);
            end
            DM_NEVER: begin
                div_valid  <= 1'b0;
                div_result <= {$urandom, $urandom};
            end
            default: begin
                if (div_start) begin
                    dm_cnt    <= 0;
                    div_valid <= 1'b0;
                end else if (dm_cnt < dm_lat) begin
                    dm_cnt <= dm_cnt + 1;
                end else begin
                    div_valid  <= 1'b1;
                    div_result <= signed_divide(div_opera2, div_opera1);
                end
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full request: accept, wait for the response, optionally back-pressure, return to IDLE
    task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs, input int mode,
                                 input int lat, input int hold, input string tag);
        logic [63:0] exp_res;
        logic [1:0]  exp_err;
        int          exp_cyc;
        int          exp_run;
        int          cyc;
        int          start_hi;
        int          run_cyc;
        bit          got;
        bit          ops_ok;

        exp_cyc = -1;
        exp_run = -1;
        if (dvs == 32'h0) begin
            exp_res = {32'h0, dvd[31:0]};
            exp_err = 2'b01;
            exp_cyc = 1;
            exp_run = 0;
        end else if (mode == DM_NEVER) begin
            exp_res = 64'h0;
            exp_err = 2'b10;
            exp_cyc = START_CYCLES + TIMEOUT_CYCLES + 1;
            exp_run = TIMEOUT_CYCLES;
        end else begin
            exp_res = signed_divide(dvd, dvs);
            exp_err = 2'b00;
            if (mode == DM_STUCK) begin
                exp_cyc = START_CYCLES + 3;
                exp_run = 2;
            end
        end

        dm_mode   = mode;
        dm_lat    = lat;
        rsp_ready = (hold == 0);
        @(negedge clock);
        req_valid    = 1'b1;
        req_dividend = dvd;
        req_divisor  = dvs;
        checkOutput({tag, ":req_ready"}, 96'(req_ready), 96'(1'b1));
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        req_dividend = {$urandom, $urandom};
        req_divisor  = $urandom;

        cyc      = 0;
        start_hi = 0;
        run_cyc  = 0;
        got      = 1'b0;
        ops_ok   = 1'b1;
        while (!got && cyc < 400) begin
            cyc++;
            if (div_opera2 !== dvd || div_opera1 !== dvs) ops_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                start_hi += int'(div_start);
                if (busy && !div_start) run_cyc++;
                @(posedge clock);
                #1;
            end
        end

        checkOutput({tag, ":got_rsp"}, 96'(got), 96'(1'b1));
        checkOutput({tag, ":result"}, 96'(rsp_result), 96'(exp_res));
        checkOutput({tag, ":err"}, 96'(rsp_err), 96'(exp_err));
        checkOutput({tag, ":start_cycles"}, 96'(start_hi), 96'((dvs == 32'h0) ? 0 : START_CYCLES));
        checkOutput({tag, ":operands_stable"}, 96'(ops_ok), 96'(1'b1));
        if (exp_cyc > 0) checkOutput({tag, ":latency"}, 96'(cyc), 96'(exp_cyc));
        if (exp_run >= 0) checkOutput({tag, ":run_cycles"}, 96'(run_cyc), 96'(exp_run));

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1;
                checkOutput({tag, ":hold"}, 96'({rsp_valid, req_ready, rsp_err, rsp_result}),
                            96'({1'b1, 1'b0, exp_err, exp_res}));
            end
            @(negedge clock);
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        checkOutput({tag, ":idle"}, 96'({rsp_valid, busy, req_ready}), 96'(3'b001));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          stale;
        logic [63:0] rdvd;
        logic [31:0] rdvs;
        int          rmode;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_dividend = 64'h0;
        req_divisor  = 32'h0;
        rsp_ready    = 1'b1;

        #1 reset = 1'b0;
        #2;
        checkOutput("reset:ctrl", 96'({req_ready, div_start, div_muordi, rsp_valid, busy, rsp_err}),
                    96'(7'b0110000));
        checkOutput("reset:opera2", 96'(div_opera2), 96'(64'h0));
        checkOutput("reset:opera1", 96'(div_opera1), 96'(32'h0));
        checkOutput("reset:result", 96'(rsp_result), 96'(64'h0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("release:idle", 96'({req_ready, div_start, div_muordi, busy}), 96'(4'b1010));

        $display("[TB] directed requests");
        applyStimulus(64'd100, 32'd7, DM_NORMAL, 3, 0, "div_100_7");
        applyStimulus(64'h0000_0001_0000_0005, 32'd0, DM_NORMAL, 3, 0, "div_zero");
        applyStimulus(64'd123456, 32'd1000, DM_STUCK, 0, 0, "stuck_valid");
        applyStimulus(64'd5000, 32'd3, DM_NEVER, 0, 0, "timeout");
        applyStimulus(64'd1000, -32'sd3, DM_NORMAL, 4, 20, "backpressure");
        applyStimulus(-64'sd100, 32'd7, DM_NORMAL, 2, 0, "signed_back2back");

        $display("[TB] reset during RUN");
        dm_mode   = DM_NEVER;
        rsp_ready = 1'b1;
        @(negedge clock);
        req_valid    = 1'b1;
        req_dividend = 64'd77;
        req_divisor  = 32'd5;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        checkOutput("midreset:in_run", 96'({busy, div_start, rsp_valid}), 96'(3'b100));
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset:ctrl", 96'({req_ready, div_start, div_muordi, rsp_valid, busy, rsp_err}),
                    96'(7'b0110000));
        checkOutput("midreset:regs", 96'({div_opera1, div_opera2}), 96'(96'h0));
        checkOutput("midreset:result", 96'(rsp_result), 96'(64'h0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checkOutput("midreset:no_stale", 96'(stale), 96'(1'b0));
        checkOutput("midreset:ready", 96'(req_ready), 96'(1'b1));

        $display("[TB] randomized requests");
        for (int n = 0; n < 16; n++) begin
            rdvd  = {{32{1'b0}}, $urandom};
            rdvd  = {{32{rdvd[31]}}, rdvd[31:0]};
            rdvs  = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'({{16{1'b0}}, 16'($urandom)});
            rdvs  = {{16{rdvs[15]}}, rdvs[15:0]};
            rmode = ($urandom_range(0, 3) == 0) ? DM_STUCK : DM_NORMAL;
            applyStimulus(rdvd, rdvs, rmode, $urandom_range(1, 6), $urandom_range(0, 3), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_req_sequencer.md
# div_req_sequencer

Request sequencer placed directly upstream of the signed divider. It accepts divide requests on a valid/ready handshake and registers the operands. It drives the divider's `start`/operand/`muordi` pins with the launch protocol the divider needs, waits for the divider's `valid`, and returns the 64-bit result on a valid/ready output handshake. It also short-circuits divide-by-zero and flags a hung divider by timeout.

## Interface
- `START_CYCLES`, default 2: cycles `div_start` is held high per launch; legal range 1..15.
- `TIMEOUT_CYCLES`, default 1023: RUN cycles allowed before a timeout error; legal range 64..65535.
- `clock`, in, 1: the only clock; everything samples on the rising edge.
- `reset`, in, 1: asynchronous, active-low; `reset`=0 forces all state and outputs to reset values immediately.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the sequencer can accept a request.
- `req_dividend`, in, 64: signed dividend.
- `req_divisor`, in, 32: signed divisor.
- `div_start`, out, 1: goes to the divider `start` pin.
- `div_muordi`, out, 1: goes to the divider `muordi` pin; constant 1 (divide) whenever not in reset.
- `div_opera2`, out, 64: goes to the divider `opera2`; the registered dividend.
- `div_opera1`, out, 32: goes to the divider `opera1`; the registered divisor.
- `div_valid`, in, 1: the divider `valid` pin; level signal.
- `div_result`, in, 64: the divider `result`; [63:32] remainder, [31:0] quotient.
- `rsp_valid`, out, 1: a response is held.
- `rsp_ready`, in, 1: the consumer accepts the response.
- `rsp_result`, out, 64: the captured result, or the error payload.
- `rsp_err`, out, 2: 00 ok, 01 divide-by-zero, 10 timeout.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, RUN, DONE; encoded 2 bits.
- IDLE
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, register dividend and divisor into `div_opera2`/`div_opera1`.
  - If divisor==0: go to DONE with `rsp_err`=01 and `rsp_result`={32'h0, dividend[31:0]}. The divider is not launched.
  - Otherwise clear `start_cnt` and go to LAUNCH.
- LAUNCH
  - `div_start`=1; increment `start_cnt`.
  - When `start_cnt`==START_CYCLES-1, go to RUN and clear `run_cnt`.
- RUN
  - `div_start`=0; `run_cnt` increments each cycle.
  - `div_valid` is ignored in the first RUN cycle (arm cycle). This blocks a stale high `valid` left over from the divider's previous operation.
  - From the second RUN cycle, `div_valid`=1 captures `div_result` into `rsp_result`, sets `rsp_err`=00, and goes to DONE.
  - If `run_cnt` reaches TIMEOUT_CYCLES first: `rsp_result`=64'h0, `rsp_err`=10, go to DONE. The divider is left running; the next launch re-clears it through `div_start`.
- DONE
  - `rsp_valid`=1; `rsp_result` and `rsp_err` stay stable until the handshake.
  - On `rsp_ready`=1, go to IDLE.
- Operand registers
  - `div_opera1`/`div_opera2` change only on an IDLE accept.
  - They stay stable through LAUNCH, RUN and DONE.
- Single outstanding request; `req_ready`=0 outside IDLE. The sequencer never accepts while it holds a response.
- Reset values: state IDLE; `req_ready`=0 while `reset`=0, then 1 from the first cycle after release; `div_start`=1, which holds the divider in its clear state; `div_muordi`=1; `div_opera1`/`div_opera2`=0; `rsp_valid`=0; `rsp_result`=0; `rsp_err`=00; `busy`=0; counters 0.
- Reset mid-operation: everything returns immediately to reset values. Any captured or pending result is discarded, and no `rsp_valid` appears afterwards.

## Timing
- Accept edge to the first `div_start` high cycle: 1 cycle.
- `div_start` is high for exactly START_CYCLES consecutive cycles, then low until the next launch.
- Response latency after the accept edge: START_CYCLES + 1 (arm) + divider latency + 1 capture cycle.
- Divide-by-zero: `rsp_valid` rises 1 cycle after the accept edge.
- `div_valid` and `rsp_ready` in the same cycle, in RUN: capture only; `rsp_ready` has no effect until DONE.
- `div_valid` on the exact cycle `run_cnt` hits TIMEOUT_CYCLES: the capture wins and `rsp_err`=00.
- `rsp_ready` held high: DONE lasts 1 cycle. The next request is accepted no earlier than the cycle after the return to IDLE.
- `req_valid` may drop without being accepted; no request is latched except in IDLE.

## Test plan
- Dividend 64'd100, divisor 32'd7, `rsp_ready`=1 → one response with `rsp_result`={32'd2, 32'd14} and `rsp_err`=00. `div_start` is high exactly 2 cycles, and `div_opera*` are stable until DONE.
- Divisor 0, dividend 64'h0000_0001_0000_0005 → `rsp_valid` 1 cycle after accept, `rsp_result`=64'h0000_0000_0000_0005, `rsp_err`=01, `div_start` never asserted.
- Divider model drives `div_valid` high before the launch and never drops it → the arm cycle masks it; the result is captured no earlier than RUN cycle 2. A model that never asserts `div_valid`, with TIMEOUT_CYCLES=64 → `rsp_err`=10 after exactly 64 RUN cycles.
- `rsp_ready` held 0 for 20 cycles after DONE → `rsp_valid`, `rsp_result`, `rsp_err` stable and `req_ready`=0 throughout. Releasing `rsp_ready` → IDLE, and a back-to-back request is accepted on the next cycle.
- `reset` pulled low in RUN cycle 10, asynchronously between edges → outputs take reset values without waiting for a clock edge. After release: IDLE, and no stale `rsp_valid`.
- Signed run: dividend −64'd100, divisor 32'd7 → `rsp_result` equals the divider model's output bit-for-bit, `rsp_err`=00.
